uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with a built-in transmit FIFO, configurable frame format and valid/ready input handshake. It sits between on-chip producers and the board `TX` pin on the PLL-derived system clock. The FIFO lets a producer burst several bytes without waiting on the serial line. Back-to-back frames go out with no idle gap.

## Interface
- `CLK_HZ`, 50250000, system clock frequency in Hz
- `BAUD`, 115200, line rate; `BAUD_DIV = CLK_HZ / BAUD`, truncating integer division; legal range 2..65535
- `DATA_BITS`, 8, payload bits per frame; legal range 5..9
- `STOP_BITS`, 1, stop bits per frame; legal values 1 or 2
- `FIFO_DEPTH`, 16, FIFO entries; power of two, legal range 2..256
- `clk`, input, 1, system clock; all logic on the rising edge
- `rst_n`, input, 1, asynchronous active-low reset
- `data_val_i`, input, 1, producer has a word on `data_in`
- `data_in`, input, `DATA_BITS`, word to send, LSB first on the line
- `data_rdy_o`, output, 1, FIFO can accept a word this cycle
- `tx`, output, 1, serial line; idles high
- `busy_o`, output, 1, a frame is in progress or the FIFO is non-empty
- `fifo_level_o`, output, `$clog2(FIFO_DEPTH)+1`, current FIFO occupancy, 0..`FIFO_DEPTH`

## Operation
- Reset values: `tx`=1, `data_rdy_o`=1, `busy_o`=0, `fifo_level_o`=0. The FIFO is empty and the FSM is in IDLE.
- Push handshake: a word is written when `data_val_i && data_rdy_o` at a rising edge.
- `data_rdy_o` = !full and is driven from registers only. It does not depend on `data_val_i`.
- Pushing while `data_rdy_o`=0 has no effect. Data is held by the producer until accepted.
- FIFO: circular buffer with read and write pointers that wrap modulo `FIFO_DEPTH`.
  - `fifo_level_o` is +1 on a push alone, -1 on a pop alone, and unchanged on a simultaneous push and pop.
  - A pop can only occur when level ≥ 1.
  - A simultaneous push and pop at level `FIFO_DEPTH` is impossible, because `data_rdy_o`=0 at full.
- FSM states, all bit periods exactly `BAUD_DIV` cycles:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head word into the shift register, drive `tx`=0, and go to START.
  - START: at the end of the bit period, output data bit 0 and go to DATA.
  - DATA: shift out `DATA_BITS` bits, LSB first. After the last bit period, go to PARITY if enabled, else STOP.
  - PARITY: one bit period (see Configuration), then STOP.
  - STOP: `tx`=1 for `STOP_BITS` bit periods. At the end, if the FIFO is non-empty, pop and go directly to START with `tx`=0 on the same edge, with no idle cycle. Otherwise go to IDLE.
- Counters:
  - The baud counter is 16 bits wide, runs 0..`BAUD_DIV-1`, and wraps to 0 at each bit boundary.
  - The bit counter counts data and stop bits within their states.
- `busy_o` = (state != IDLE) || (level != 0).
- Reset mid-frame: `tx` returns to 1 immediately (asynchronously), the FIFO is flushed, and the partial frame is abandoned.

## Timing
- Push into an empty FIFO with the FSM in IDLE at edge N: level is 1 after N; the pop happens at N+1, and the start bit (`tx`=0) is visible after N+1.
- Frame length in cycles: `BAUD_DIV` × (1 + `DATA_BITS` + P + `STOP_BITS`), where P=1 if parity is compiled in, else 0.
- Consecutive frames are exactly one frame length apart while the FIFO stays non-empty.
- `data_rdy_o` rises on the edge after a pop that takes the FIFO below full.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - Adds parameter `PARITY_ODD` (default 0) and the PARITY state.
  - The parity bit is XOR of the data bits for even parity, or its inverse when `PARITY_ODD`=1.
- `UART_TX_PARITY_EN` undefined:
  - No PARITY state and no parity logic.
  - Frame is start + data + stop only.

## Test plan
- Basic frame: defaults, parity off, push 0x48 once.
  - Required: `tx` = 0,0,0,0,1,0,0,1,0,1, each level held 436 cycles (4360 total).
  - Required: `busy_o` falls on the edge after the stop bit ends.
- Burst to full: push 17 words back-to-back with `FIFO_DEPTH`=16.
  - Required: one word pops into the shifter, so 17 are accepted before `data_rdy_o`=0 and level=16.
  - Required: frames are contiguous with no idle-high gap longer than the stop bit.
- Format sweep: `DATA_BITS`=7, `STOP_BITS`=2, `BAUD_DIV`=4, push 0x55.
  - Required: line pattern 0,1,0,1,0,1,0,1,1,1, each bit 4 cycles.
- Parity: `UART_TX_PARITY_EN` defined, push 0x48.
  - Required: parity bit is 0 with `PARITY_ODD`=0 and 1 with `PARITY_ODD`=1.
  - Required: frame is 11 bit periods.
- Wrap-around: push and pop continuously, more than 3×`FIFO_DEPTH` words (for example 50 with depth 16).
  - Required: every received byte matches the push order.
  - Required: `fifo_level_o` never exceeds 16 and never underflows.
- Reset mid-frame: assert `rst_n`=0 during the DATA state with 5 words queued.
  - Required: `tx`=1 immediately, level=0, `data_rdy_o`=1, `busy_o`=0.
  - Required: after release, nothing is transmitted until a new push.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a circular transmit FIFO and valid/ready push handshake.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN.
module uart_tx_fifo #(
    parameter int unsigned CLK_HZ     = 50250000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit          PARITY_ODD = 1'b0
`endif
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            data_val_i,
    input  logic [DATA_BITS-1:0]            data_in,
    output logic                            data_rdy_o,
    output logic                            tx,
    output logic                            busy_o,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o
);

    localparam int unsigned BAUD_DIV = CLK_HZ / BAUD;
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned LW       = AW + 1;

    localparam logic [15:0]   DivLast  = 16'(BAUD_DIV - 1);
    localparam logic [3:0]    DataLast = 4'(DATA_BITS - 1);
    localparam logic [3:0]    StopLast = 4'(STOP_BITS - 1);
    localparam logic [LW-1:0] LvlFull  = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop
`ifdef UART_TX_PARITY_EN
        ,
        StParity
`endif
    } state_e;

    state_e                 state_q, state_d;
    logic [15:0]            baud_q, baud_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]          level_q, level_d;
`ifdef UART_TX_PARITY_EN
    logic                   par_q, par_d;
`endif

    logic push, pop, empty, tick;

    assign empty        = (level_q == '0);
    assign tick         = (baud_q == DivLast);
    assign push         = data_val_i && data_rdy_o;
    assign data_rdy_o   = (level_q != LvlFull);
    assign tx           = tx_q;
    assign busy_o       = (state_q != StIdle) || !empty;
    assign fifo_level_o = level_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != StIdle) begin
            baud_d = tick ? '0 : baud_q + 16'd1;
        end

        unique case (state_q)
            StIdle: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    tx_d    = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (tick) begin
                    if (bit_q == DataLast) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = StParity;
`else
                        tx_d    = 1'b1;
                        bit_d   = '0;
                        state_d = StStop;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 4'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    bit_d   = '0;
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    if (bit_q == StopLast) begin
                        // Chain straight into the next start bit when more data waits.
                        if (!empty) begin
                            pop     = 1'b1;
                            tx_d    = 1'b0;
                            state_d = StStart;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (pop) begin
            shift_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
            par_d   = (^mem_q[rd_ptr_q]) ^ PARITY_ODD;
`endif
        end
    end

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            level_q  <= level_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (default timing and a fast 7-bit/2-stop one)
// checked every cycle against a frame-level queue model plus literal frame patterns.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int DIV_A = 436;
    localparam int DB_A  = 8;
    localparam int SB_A  = 1;
    localparam int DIV_B = 4;
    localparam int DB_B  = 7;
    localparam int SB_B  = 2;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_a_n, rst_b_n, val_a, val_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       rdy_a, rdy_b, tx_a, tx_b, busy_a, busy_b;
    logic [4:0] lvl_a, lvl_b;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo #(
        .DATA_BITS (8),
        .STOP_BITS (1),
        .FIFO_DEPTH(16)
`ifdef UART_TX_PARITY_EN
        ,
        .PARITY_ODD(1'b0)
`endif
    ) u_a (
        .clk         (clk),
        .rst_n       (rst_a_n),
        .data_val_i  (val_a),
        .data_in     (data_a),
        .data_rdy_o  (rdy_a),
        .tx          (tx_a),
        .busy_o      (busy_a),
        .fifo_level_o(lvl_a)
    );

    uart_tx_fifo #(
        .CLK_HZ    (40),
        .BAUD      (10),
        .DATA_BITS (7),
        .STOP_BITS (2),
        .FIFO_DEPTH(16)
`ifdef UART_TX_PARITY_EN
        ,
        .PARITY_ODD(1'b1)
`endif
    ) u_b (
        .clk         (clk),
        .rst_n       (rst_b_n),
        .data_val_i  (val_b),
        .data_in     (data_b),
        .data_rdy_o  (rdy_b),
        .tx          (tx_b),
        .busy_o      (busy_b),
        .fifo_level_o(lvl_b)
    );

    // ---------------- frame-level model ----------------
    int         mcnt  [2];
    int         mhead [2];
    int         mpos  [2];
    bit         mact  [2];
    logic [8:0] mword [2];
    logic [8:0] mmem  [2][256];

    function automatic int kdiv(int k);  return (k == 1) ? DIV_B : DIV_A; endfunction
    function automatic int kdb(int k);   return (k == 1) ? DB_B : DB_A;   endfunction
    function automatic int kflen(int k);
        return kdiv(k) * (1 + kdb(k) + P + ((k == 1) ? SB_B : SB_A));
    endfunction

    task automatic model_reset(int k);
        mcnt[k] = 0; mhead[k] = 0; mpos[k] = 0; mact[k] = 1'b0;
    endtask

    task automatic model_step(int k, logic v, logic [8:0] d);
        int pre;
        pre = mcnt[k];
        if (mact[k]) begin
            if (mpos[k] == kflen(k) - 1) mact[k] = 1'b0;
            else mpos[k]++;
        end
        if (!mact[k] && pre > 0) begin
            mword[k] = mmem[k][mhead[k]];
            mhead[k] = (mhead[k] + 1) % 256;
            mcnt[k]--;
            mact[k] = 1'b1;
            mpos[k] = 0;
        end
        if (v && pre < DEPTH) begin
            mmem[k][(mhead[k] + mcnt[k]) % 256] = d;
            mcnt[k]++;
        end
    endtask

    function automatic logic exp_tx(int k);
        int   idx;
        logic p;
        if (!mact[k]) return 1'b1;
        idx = mpos[k] / kdiv(k);
        if (idx == 0) return 1'b0;
        if (idx <= kdb(k)) return mword[k][idx-1];
        if (P == 1 && idx == kdb(k) + 1) begin
            p = (k == 1);
            for (int i = 0; i < kdb(k); i++) p ^= mword[k][i];
            return p;
        end
        return 1'b1;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_a_n);
        if (!rst_a_n) model_reset(0);
        else model_step(0, val_a, {1'b0, data_a});
    end

    initial forever begin
        @(posedge clk or negedge rst_b_n);
        if (!rst_b_n) model_reset(1);
        else model_step(1, val_b, {2'b0, data_b});
    end

    // ---------------- checking ----------------
    task automatic chk(string name, int got, int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic check_inst(int k, logic t, logic r, logic b, logic [4:0] l);
        logic       et, er, eb;
        logic [4:0] el;
        et = exp_tx(k);
        er = (mcnt[k] < DEPTH);
        eb = mact[k] || (mcnt[k] != 0);
        el = 5'(mcnt[k]);
        tests++;
        if ({t, r, b, l} !== {et, er, eb, el}) begin
            fails++;
            $display("FAIL model_cmp inst%0d cyc %0d: tx/rdy/busy/lvl got %b/%b/%b/%0d want %b/%b/%b/%0d",
                     k, cyc, t, r, b, l, et, er, eb, el);
        end
    endtask

    int maxl_b = 0;
    initial forever begin
        @(negedge clk);
        check_inst(0, tx_a, rdy_a, busy_a, lvl_a);
        check_inst(1, tx_b, rdy_b, busy_b, lvl_b);
        if (int'(lvl_b) > maxl_b) maxl_b = int'(lvl_b);
    end

    // Busy falling-edge timestamps, in posedge counts.
    int fall_cyc [2];
    bit bprev [2];
    initial forever begin
        @(negedge clk);
        if (bprev[0] && !busy_a) fall_cyc[0] = cyc;
        if (bprev[1] && !busy_b) fall_cyc[1] = cyc;
        bprev[0] = busy_a;
        bprev[1] = busy_b;
    end

    // Independent line receiver on instance B.
    bit         rx_en = 1'b0;
    logic [6:0] rx_w;
    logic [6:0] rxq [$];
    initial forever begin
        @(negedge clk);
        if (rx_en && tx_b === 1'b0) begin
            repeat (DIV_B / 2) @(negedge clk);
            for (int i = 0; i < DB_B; i++) begin
                repeat (DIV_B) @(negedge clk);
                rx_w[i] = tx_b;
            end
            repeat (DIV_B * (1 + P)) @(negedge clk);
            rxq.push_back(rx_w);
        end
    end

    function automatic logic txk(int k);   return (k == 1) ? tx_b : tx_a;   endfunction
    function automatic logic rdyk(int k);  return (k == 1) ? rdy_b : rdy_a; endfunction

    task automatic push_word(int k, logic [7:0] d);
        int t;
        t = 0;
        @(negedge clk);
        if (k == 1) begin val_b = 1'b1; data_b = d[6:0]; end
        else begin val_a = 1'b1; data_a = d; end
        while (!rdyk(k) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) chk("push_timeout", t, 0);
        @(negedge clk);
        val_a = 1'b0;
        val_b = 1'b0;
    endtask

    task automatic capture(int k, int nbits, output logic [11:0] bits, output int start);
        int t;
        t = 0;
        bits = '0;
        start = cyc;
        while (txk(k) !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            chk("frame_start_timeout", t, 0);
        end else begin
            start = cyc;
            repeat (kdiv(k) / 2) @(negedge clk);
            for (int i = 0; i < nbits; i++) begin
                bits[i] = txk(k);
                repeat (kdiv(k)) @(negedge clk);
            end
        end
    endtask

    task automatic reset_pulse(int k, string name);
        @(negedge clk);
        #2;
        if (k == 1) rst_b_n = 1'b0; else rst_a_n = 1'b0;
        #1;
        chk({name, "_tx"},   (k == 1) ? tx_b : tx_a, 1);
        chk({name, "_lvl"},  (k == 1) ? lvl_b : lvl_a, 0);
        chk({name, "_rdy"},  (k == 1) ? rdy_b : rdy_a, 1);
        chk({name, "_busy"}, (k == 1) ? busy_b : busy_a, 0);
        repeat (3) @(negedge clk);
        if (k == 1) rst_b_n = 1'b1; else rst_a_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    logic [11:0] bits;
    int          st, acc, lows, t;
    bit          ok;

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        val_a = 1'b0; val_b = 1'b0; data_a = '0; data_b = '0;
        repeat (3) @(negedge clk);
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        @(negedge clk);
        chk("rst_tx_a", tx_a, 1);   chk("rst_rdy_a", rdy_a, 1);
        chk("rst_busy_a", busy_a, 0); chk("rst_lvl_a", lvl_a, 0);
        chk("rst_tx_b", tx_b, 1);   chk("rst_lvl_b", lvl_b, 0);

        // Basic frame, 0x48 at 436 cycles/bit.
        push_word(0, 8'h48);
        capture(0, 10 + P, bits, st);
        chk("frame_a_bits", int'(bits), (P == 1) ? 1168 : 656);
        chk("frame_a_len", fall_cyc[0] - st, DIV_A * (10 + P));
        if (P == 1) chk("parity_even_bit", int'(bits[9]), 0);

        // Burst to full with valid held high.
        @(negedge clk);
        val_a = 1'b1; data_a = 8'd0; acc = 0;
        for (int c = 0; c < 20; c++) begin
            ok = rdy_a;
            @(negedge clk);
            if (ok) begin acc++; data_a = 8'(acc); end
        end
        val_a = 1'b0;
        chk("burst_accepted", acc, 17);
        chk("burst_level", lvl_a, 16);
        chk("burst_rdy", rdy_a, 0);
        repeat (1000) @(negedge clk);
        reset_pulse(0, "rst_a_mid");

        // Format sweep on B: 7 data bits, 2 stop bits, 4 cycles/bit.
        push_word(1, 8'h55);
        capture(1, 10 + P, bits, st);
        chk("frame_b55_bits", int'(bits), (P == 1) ? 1962 : 938);
        chk("frame_b_len", fall_cyc[1] - st, DIV_B * (10 + P));
        push_word(1, 8'h48);
        capture(1, 10 + P, bits, st);
        chk("frame_b48_bits", int'(bits), (P == 1) ? 1936 : 912);
        if (P == 1) chk("parity_odd_bit", int'(bits[8]), 1);
        repeat (20) @(negedge clk);

        // Reset mid-frame with five words queued.
        for (int i = 0; i < 6; i++) push_word(1, 8'(8'h10 + i));
        chk("queued_before_rst", lvl_b, 5);
        chk("in_frame_before_rst", busy_b, 1);
        reset_pulse(1, "rst_b_mid");
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx_b === 1'b0) lows++;
        end
        chk("idle_after_rst", lows, 0);

        // Wrap-around: 50 words through the 16-deep FIFO.
        rx_en = 1'b1;
        for (int i = 0; i < 50; i++) push_word(1, 8'((i * 37 + 5) & 8'h7f));
        t = 0;
        while (busy_b && t < 8000) begin
            @(negedge clk);
            t++;
        end
        chk("wrap_drained", busy_b, 0);
        repeat (20) @(negedge clk);
        chk("wrap_rx_count", rxq.size(), 50);
        for (int i = 0; i < 50 && i < rxq.size(); i++)
            chk("wrap_rx_byte", int'(rxq[i]), (i * 37 + 5) & 8'h7f);
        chk("wrap_max_level_ok", int'(maxl_b <= DEPTH), 1);
        chk("wrap_filled", int'(maxl_b >= 8), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
